// File: rtl/sqrt_reconstruct_pkg.sv
// ============================================================================
// Module  : sqrt_reconstruct_pkg
// Brief   : Shared sizing and FSM encodings for the sqrt and square units.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sqrt_reconstruct_pkg;

  localparam int SQRT_WIDTH = 16;
  localparam int SQRT_HALF  = SQRT_WIDTH / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sqrt_reconstruct_datapath.sv
// ============================================================================
// Module  : sqrt_reconstruct_datapath
// Brief   : Shift-add Q*Q+R datapath with accumulator, multiplicand, multiplier
//           and step counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_reconstruct_datapath #(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2,
  parameter int CW    = $clog2(HALF + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              latch,
  input  logic [HALF-1:0]   Q_in,
  input  logic [HALF:0]     R_in,
  output logic [WIDTH-1:0]  D_out,
  output logic              err,
  output logic              count_is_1,
  output logic              b_lsb
);

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_m;
  logic [HALF-1:0]  r_b;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   w_acc_next;

  assign w_acc_next = r_b[0] ? (r_acc + {1'b0, r_m}) : r_acc;
  assign count_is_1 = (r_count == CW'(1));
  assign b_lsb      = r_b[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_m     <= '0;
      r_b     <= '0;
      r_count <= '0;
      D_out   <= '0;
      err     <= 1'b0;
    end else begin
      if (load) begin
        r_acc   <= {{(WIDTH-HALF){1'b0}}, R_in};
        r_m     <= {{(WIDTH-HALF){1'b0}}, Q_in};
        r_b     <= Q_in;
        r_count <= CW'(HALF);
        err     <= (R_in > {Q_in, 1'b0});
      end else if (step) begin
        r_acc   <= w_acc_next;
        r_m     <= r_m << 1;
        r_b     <= r_b >> 1;
        r_count <= r_count - CW'(1);
      end
      // Capture the final sum on the last step so D_out is valid alongside done.
      if (latch) begin
        D_out <= w_acc_next[WIDTH-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sqrt_reconstruct.sv
// ============================================================================
// Module  : sqrt_reconstruct
// Brief   : Rebuilds radicand D = Q*Q + R, one multiplier bit per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_reconstruct
  import sqrt_reconstruct_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH/2-1:0]   Q_in,
  input  logic [WIDTH/2:0]     R_in,
  output logic [WIDTH-1:0]     D_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int HALF = WIDTH / 2;

  state_t r_state;
  logic   w_load;
  logic   w_step;
  logic   w_latch;
  logic   w_count_is_1;
  logic   w_b_lsb;

  assign w_load  = (r_state == S_IDLE) && start;
  assign w_step  = (r_state == S_MUL);
  assign w_latch = w_step && w_count_is_1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= S_MUL;
            busy    <= 1'b1;
          end
        end
        S_MUL: begin
          if (w_count_is_1) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  sqrt_reconstruct_datapath #(
    .WIDTH (WIDTH),
    .HALF  (HALF)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .step       (w_step),
    .latch      (w_latch),
    .Q_in       (Q_in),
    .R_in       (R_in),
    .D_out      (D_out),
    .err        (err),
    .count_is_1 (w_count_is_1),
    .b_lsb      (w_b_lsb)
  );

  // Multiplier LSB is consumed inside the datapath; exposed for debug only.
  logic w_unused;
  assign w_unused = w_b_lsb;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_reconstruct.sv
// ============================================================================
// Module  : tb_sqrt_reconstruct
// Brief   : Directed and randomized bench for sqrt_reconstruct.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqrt_reconstruct;

  localparam int WIDTH = 16;
  localparam int HALF  = WIDTH / 2;
  localparam int LAT   = HALF + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [HALF-1:0]  Q_in = '0;
  logic [HALF:0]    R_in = '0;
  logic [WIDTH-1:0] D_out;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sqrt_reconstruct #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Q_in  (Q_in),
    .R_in  (R_in),
    .D_out (D_out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int d);
    int q = 0;
    for (int i = 0; i < (1 << HALF); i++)
      if (i * i <= d) q = i;
    return q;
  endfunction

  // Reference: D = (Q^2 + R) mod 2^WIDTH, err when R > 2Q.
  // When repulse is set, a second start with other operands is issued mid-run.
  task automatic run_op(input int q, input int r, input bit repulse, input string tag);
    int exp_d;
    int exp_e;
    int lat;
    int dones;
    exp_d = (q * q + r) % (1 << WIDTH);
    exp_e = (r > 2 * q) ? 1 : 0;
    @(negedge clk);
    Q_in  = q[HALF-1:0];
    R_in  = r[HALF:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Q_in  = HALF'($urandom);
    R_in  = (HALF+1)'($urandom);
    lat   = 1;
    dones = 0;
    check({tag, "_busy_start"}, busy, 1);
    while (!done && lat < 3 * LAT) begin
      if (repulse && lat == 3) begin
        start = 1'b1;
        Q_in  = q[HALF-1:0] ^ 8'h5A;
        R_in  = 9'h003;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (!done) check({tag, "_busy_mul"}, busy, 1);
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_D_out"}, D_out, exp_d);
    check({tag, "_err"}, err, exp_e);
    check({tag, "_busy_done"}, busy, 1);
    dones = done ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, "_one_done"}, dones, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_D_hold"}, D_out, exp_d);
    check({tag, "_err_hold"}, err, exp_e);
  endtask

  initial begin
    int q;
    int r;
    int d;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_D_out", D_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;

    run_op(8'hB5, 9'h000, 1'b0, "b5_sq");
    run_op(8'hFF, 9'h1FE, 1'b0, "max_valid");
    run_op(8'h03, 9'h007, 1'b0, "invalid");
    run_op(8'h00, 9'h000, 1'b0, "zero");
    run_op(8'hFF, 9'h1FF, 1'b0, "invalid_wrap");

    // Round trip through a reference integer square root.
    q = isqrt(1000);
    r = 1000 - q * q;
    check("isqrt_1000_q", q, 31);
    check("isqrt_1000_r", r, 39);
    run_op(q, r, 1'b0, "rt_1000");
    for (int i = 0; i < 40; i++) begin
      d = (i == 0) ? 65535 : (i == 1) ? 1 : int'($urandom_range(0, 65535));
      q = isqrt(d);
      r = d - q * q;
      run_op(q, r, 1'b0, "rt_rand");
    end

    // Random operand pairs, valid and invalid.
    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)), 1'b0, "rand");

    run_op(8'hC3, 9'h010, 1'b1, "repulse");

    // Asynchronous reset in the middle of MUL.
    @(negedge clk);
    Q_in  = 8'h77;
    R_in  = 9'h005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_D_out", D_out, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run_op(8'h10, 9'h000, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
